// File: rtl/sram_pkg.sv
// Shared types and defaults for the SRAM arbiter: FSM states, owner tag,
// PHY command encoding and the default timing parameters.
package sram_pkg;

  localparam int ADDR_W     = 18;
  localparam int DATA_W     = 16;
  localparam int RD_CYC_DEF = 2;
  localparam int WR_CYC_DEF = 2;
  localparam int STARVE_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_WR      = 3'd2,
    ST_WR_HOLD = 3'd3,
    ST_ACK     = 3'd4
  } state_e;

  typedef enum logic {
    OWN_VID  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  // Command for the PHY, describing what the strobes do in the coming cycle.
  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_HOLD  = 2'd3
  } phy_cmd_e;

  // Bits needed to hold the values 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    if (n < 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/sram_phy.sv
// SRAM pin driver: registered strobes and address, write-data tristate,
// and per-owner read-sample registers.
module sram_phy
  import sram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  phy_cmd_e          cmd_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        lanes_i,
  input  logic              sample_vid_i,
  input  logic              sample_host_i,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic              sram_ub_n_o,
  output logic              sram_lb_n_o,
  inout  wire  [DATA_W-1:0] sram_dq_io,
  output logic [DATA_W-1:0] vid_rdata_o,
  output logic [DATA_W-1:0] host_rdata_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        lanes_q, lanes_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              ub_n_q, ub_n_d;
  logic              lb_n_q, lb_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic [DATA_W-1:0] vid_rd_q, vid_rd_d;
  logic [DATA_W-1:0] host_rd_q, host_rd_d;

  // Next-state of the pin registers from the command for the coming cycle.
  always_comb begin
    if (load_i) begin
      addr_d  = addr_i;
      wdata_d = wdata_i;
      lanes_d = lanes_i;
    end else begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      lanes_d = lanes_q;
    end

    case (cmd_i)
      CMD_READ: begin
        ce_n_d  = 1'b0;
        oe_n_d  = 1'b0;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
      CMD_WRITE: begin
        ce_n_d  = 1'b0;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      CMD_HOLD: begin
        ce_n_d  = 1'b0;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b1;
      end
      default: begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
    endcase

    if (cmd_i == CMD_IDLE) begin
      ub_n_d = 1'b1;
      lb_n_d = 1'b1;
    end else begin
      ub_n_d = ~lanes_d[1];
      lb_n_d = ~lanes_d[0];
    end

    if (sample_vid_i) begin
      vid_rd_d = sram_dq_io;
    end else begin
      vid_rd_d = vid_rd_q;
    end

    if (sample_host_i) begin
      host_rd_d = sram_dq_io;
    end else begin
      host_rd_d = host_rd_q;
    end
  end

  // Pin and read-data registers; reset parks every strobe high.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      lanes_q   <= 2'b00;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      ub_n_q    <= 1'b1;
      lb_n_q    <= 1'b1;
      dq_oe_q   <= 1'b0;
      vid_rd_q  <= '0;
      host_rd_q <= '0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      lanes_q   <= lanes_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      ub_n_q    <= ub_n_d;
      lb_n_q    <= lb_n_d;
      dq_oe_q   <= dq_oe_d;
      vid_rd_q  <= vid_rd_d;
      host_rd_q <= host_rd_d;
    end
  end

  assign sram_dq_io   = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
  assign sram_addr_o  = addr_q;
  assign sram_ce_n_o  = ce_n_q;
  assign sram_oe_n_o  = oe_n_q;
  assign sram_we_n_o  = we_n_q;
  assign sram_ub_n_o  = ub_n_q;
  assign sram_lb_n_o  = lb_n_q;
  assign vid_rdata_o  = vid_rd_q;
  assign host_rdata_o = host_rd_q;

endmodule

// File: rtl/sram_arbiter.sv
// Two-port asynchronous-SRAM arbiter: video has priority, host is protected
// from starvation by a bounded count of consecutive video grants.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int RD_CYC = RD_CYC_DEF,
  parameter int WR_CYC = WR_CYC_DEF,
  parameter int STARVE = STARVE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [1:0]        host_be,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  output logic              busy
);

  localparam int CYC_MAX = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int CNT_W   = cnt_w(CYC_MAX);
  localparam int SW      = cnt_w(STARVE + 1);

  localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RD_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WR_CYC - 1);
  localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              vid_ack_q, vid_ack_d;
  logic              host_ack_q, host_ack_d;
  logic              busy_q, busy_d;

  phy_cmd_e          cmd;
  logic              load;
  logic [ADDR_W-1:0] ld_addr;
  logic [1:0]        lanes;
  logic              sample_vid;
  logic              sample_host;
  logic              host_wins;
  logic [SW-1:0]     starve_inc;

  assign host_wins  = host_req && (starve_q == STARVE_MAX);
  assign starve_inc = (starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1);

  // Arbitration and access sequencing; also produces the PHY command for the next cycle.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    vid_ack_d   = 1'b0;
    host_ack_d  = 1'b0;
    cmd         = CMD_IDLE;
    load        = 1'b0;
    ld_addr     = host_addr;
    lanes       = host_be;
    sample_vid  = 1'b0;
    sample_host = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (vid_req && !host_wins) begin
          state_d  = ST_RD;
          owner_d  = OWN_VID;
          cnt_d    = '0;
          load     = 1'b1;
          ld_addr  = vid_addr;
          lanes    = 2'b11;
          cmd      = CMD_READ;
          starve_d = host_req ? starve_inc : '0;
        end else if (host_req) begin
          state_d  = host_we ? ST_WR : ST_RD;
          owner_d  = OWN_HOST;
          cnt_d    = '0;
          load     = 1'b1;
          cmd      = host_we ? CMD_WRITE : CMD_READ;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
      end
      ST_RD: begin
        if (cnt_q == RD_LAST) begin
          // oe_n is still low across this edge, so dq is captured here.
          state_d     = ST_ACK;
          sample_vid  = (owner_q == OWN_VID);
          sample_host = (owner_q == OWN_HOST);
          vid_ack_d   = (owner_q == OWN_VID);
          host_ack_d  = (owner_q == OWN_HOST);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          cmd   = CMD_READ;
        end
      end
      ST_WR: begin
        if (cnt_q == WR_LAST) begin
          state_d = ST_WR_HOLD;
          cmd     = CMD_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          cmd   = CMD_WRITE;
        end
      end
      ST_WR_HOLD: begin
        state_d    = ST_ACK;
        vid_ack_d  = (owner_q == OWN_VID);
        host_ack_d = (owner_q == OWN_HOST);
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!host_req) begin
      starve_d = '0;
    end else begin
      starve_d = starve_d;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // FSM state, starvation counter and registered acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_VID;
      cnt_q      <= '0;
      starve_q   <= '0;
      vid_ack_q  <= 1'b0;
      host_ack_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      vid_ack_q  <= vid_ack_d;
      host_ack_q <= host_ack_d;
      busy_q     <= busy_d;
    end
  end

  sram_phy u_phy (
    .clk           (clk),
    .rst           (rst),
    .cmd_i         (cmd),
    .load_i        (load),
    .addr_i        (ld_addr),
    .wdata_i       (host_wdata),
    .lanes_i       (lanes),
    .sample_vid_i  (sample_vid),
    .sample_host_i (sample_host),
    .sram_addr_o   (sram_addr),
    .sram_ce_n_o   (sram_ce_n),
    .sram_oe_n_o   (sram_oe_n),
    .sram_we_n_o   (sram_we_n),
    .sram_ub_n_o   (sram_ub_n),
    .sram_lb_n_o   (sram_lb_n),
    .sram_dq_io    (sram_dq),
    .vid_rdata_o   (vid_rdata),
    .host_rdata_o  (host_rdata)
  );

  assign vid_ack  = vid_ack_q;
  assign host_ack = host_ack_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM, ack-driven
// scoreboards and per-cycle strobe/tristate protocol checks.
module tb_sram_arbiter;

  typedef struct {
    logic        is_read;
    logic [15:0] data;
  } host_exp_t;

  logic        clk;
  logic        rst;
  logic        vid_req;
  logic [17:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_rdata;
  logic        host_req;
  logic        host_we;
  logic [17:0] host_addr;
  logic [15:0] host_wdata;
  logic [1:0]  host_be;
  logic        host_ack;
  logic [15:0] host_rdata;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic [15:0] mem [0:262143];
  logic [15:0] vid_sb[$];
  host_exp_t   host_sb[$];
  logic [15:0] mon_v;
  host_exp_t   mon_h;

  sram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_ack    (vid_ack),
    .vid_rdata  (vid_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_be    (host_be),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .sram_dq    (sram_dq),
    .sram_addr  (sram_addr),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM: drives dq while selected with oe_n low.
  assign sram_dq = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
      if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Per-cycle protocol checks and scoreboard pops on each ack.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("oe_we_overlap", {31'd0, (!sram_oe_n && !sram_we_n)}, 32'd0);
      chk("dq_drive_window", {31'd0, dut.u_phy.dq_oe_q}, {31'd0, (!sram_ce_n && sram_oe_n)});
      if (vid_ack) begin
        chk("vid_ack_expected", {31'd0, (vid_sb.size() != 0)}, 32'd1);
        if (vid_sb.size() != 0) begin
          mon_v = vid_sb.pop_front();
          chk("vid_rdata", {16'd0, vid_rdata}, {16'd0, mon_v});
        end
      end
      if (host_ack) begin
        chk("host_ack_expected", {31'd0, (host_sb.size() != 0)}, 32'd1);
        if (host_sb.size() != 0) begin
          mon_h = host_sb.pop_front();
          if (mon_h.is_read) chk("host_rdata", {16'd0, host_rdata}, {16'd0, mon_h.data});
        end
      end
    end
  end

  task automatic host_access(input logic we, input logic [17:0] addr, input logic [15:0] wd,
                             input logic [1:0] be, input logic [15:0] exp_rd,
                             input int exp_lat, input int exp_vid, input string tag);
    int n, vseen;
    logic got, ubl, lbl;
    host_exp_t e;
    e.is_read = !we;
    e.data    = exp_rd;
    host_sb.push_back(e);
    host_we = we; host_addr = addr; host_wdata = wd; host_be = be; host_req = 1'b1;
    n = 0; vseen = 0; got = 1'b0; ubl = 1'b0; lbl = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (!sram_ce_n && !sram_ub_n) ubl = 1'b1;
      if (!sram_ce_n && !sram_lb_n) lbl = 1'b1;
      if (vid_ack) vseen++;
      if (host_ack) got = 1'b1;
    end
    host_req = 1'b0;
    chk({tag, "_ack"}, {31'd0, got}, 32'd1);
    if (exp_lat > 0) begin
      chk({tag, "_latency"}, n, exp_lat);
      chk({tag, "_ub_active"}, {31'd0, ubl}, {31'd0, be[1]});
      chk({tag, "_lb_active"}, {31'd0, lbl}, {31'd0, be[0]});
      chk({tag, "_busy_in_ack"}, {31'd0, busy}, 32'd1);
    end
    if (exp_vid >= 0) chk({tag, "_vid_acks_before"}, vseen, exp_vid);
    @(posedge clk); #1;
    if (exp_lat > 0) chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic vid_burst(input int n, input logic [17:0] addr, input logic [15:0] exp);
    int k, t;
    for (int i = 0; i < n; i++) vid_sb.push_back(exp);
    vid_addr = addr; vid_req = 1'b1;
    k = 0; t = 0;
    while (k < n && t < n * 20 + 50) begin
      @(posedge clk); #1;
      t++;
      if (vid_ack) k++;
    end
    vid_req = 1'b0;
    chk("vid_burst_acks", k, n);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, t, acks;
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
    rst = 1'b1; vid_req = 1'b0; vid_addr = 18'h0; host_req = 1'b0; host_we = 1'b0;
    host_addr = 18'h0; host_wdata = 16'h0; host_be = 2'b00;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1f);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_dq_oe", {31'd0, dut.u_phy.dq_oe_q}, 32'd0);
    chk("rst_acks", {30'd0, vid_ack, host_ack}, 32'd0);
    chk("rst_rdata", {vid_rdata, host_rdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Host write/read with full and partial byte enables
    host_access(1'b1, 18'h2A5C5, 16'hBEEF, 2'b11, 16'h0000, 4, 0, "wr_beef");
    host_access(1'b0, 18'h2A5C5, 16'h0000, 2'b11, 16'hBEEF, 3, 0, "rd_beef");
    host_access(1'b1, 18'h2A5C5, 16'h1234, 2'b01, 16'h0000, 4, 0, "wr_be01");
    host_access(1'b0, 18'h2A5C5, 16'h0000, 2'b11, 16'hBE34, 3, 0, "rd_be34");
    host_access(1'b1, 18'h2A5C5, 16'hFFFF, 2'b00, 16'h0000, 4, 0, "wr_be00");
    host_access(1'b0, 18'h2A5C5, 16'h0000, 2'b11, 16'hBE34, 3, 0, "rd_after_be00");
    host_access(1'b1, 18'h01234, 16'h5A5A, 2'b11, 16'h0000, 4, 0, "wr_vid_data");

    // Simultaneous requests: video first, host on the next arbitration
    fork
      vid_burst(1, 18'h01234, 16'h5A5A);
      host_access(1'b0, 18'h2A5C5, 16'h0000, 2'b11, 16'hBE34, 7, 1, "rd_simul");
    join

    // Starvation bound with video held continuously
    fork
      vid_burst(20, 18'h01234, 16'h5A5A);
      begin
        k = 0; t = 0;
        while (k < 2 && t < 100) begin
          @(posedge clk); #1;
          t++;
          if (vid_ack) k++;
        end
        chk("starve_pre_acks", k, 2);
        host_access(1'b0, 18'h2A5C5, 16'h0000, 2'b11, 16'hBE34, 0, 8, "starve_1");
        host_access(1'b0, 18'h2A5C5, 16'h0000, 2'b11, 16'hBE34, 0, 8, "starve_2");
      end
    join

    // Reset during the second write cycle aborts without an ack
    host_we = 1'b1; host_addr = 18'h00F0F; host_wdata = 16'hCAFE; host_be = 2'b11; host_req = 1'b1;
    @(posedge clk); #1;
    chk("abort_wr1_we", {31'd0, sram_we_n}, 32'd0);
    @(posedge clk); #1;
    chk("abort_wr2_we", {31'd0, sram_we_n}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1f);
    chk("abort_dq_oe", {31'd0, dut.u_phy.dq_oe_q}, 32'd0);
    chk("abort_ack", {31'd0, host_ack}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rdata", {vid_rdata, host_rdata}, 32'd0);
    rst = 1'b0; host_req = 1'b0;
    acks = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (host_ack) acks++;
    end
    chk("abort_no_ack", acks, 0);

    // Service resumes normally
    host_access(1'b0, 18'h2A5C5, 16'h0000, 2'b11, 16'hBE34, 3, 0, "rd_post_abort");
    vid_burst(1, 18'h01234, 16'h5A5A);

    chk("vid_sb_drained", vid_sb.size(), 0);
    chk("host_sb_drained", host_sb.size(), 0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter RD_CYC, default 2, SHALL set the cycles oe_n is held low per read.
REQ-002 Parameter WR_CYC, default 2, SHALL set the cycles we_n is held low per write.
REQ-003 Parameter STARVE, default 8, SHALL set the maximum consecutive video grants while host_req is pending.
REQ-004 clk  in  1  single system clock (108 MHz domain); all logic SHALL be on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 vid_req  in  1  video read request, level, held until vid_ack.
REQ-007 vid_addr  in  18  video word address, stable while vid_req is high.
REQ-008 vid_ack  out  1  one-cycle pulse, vid_rdata valid in the same cycle.
REQ-009 vid_rdata  out  16  video read data, registered.
REQ-010 host_req  in  1  host request, level, held until host_ack.
REQ-011 host_we  in  1  1=write, 0=read.
REQ-012 host_addr  in  18  host word address.
REQ-013 host_wdata  in  16  host write data.
REQ-014 host_be  in  2  byte enables, [1]=upper byte, [0]=lower byte.
REQ-015 host_ack  out  1  one-cycle pulse; on reads host_rdata is valid in the same cycle.
REQ-016 host_rdata  out  16  host read data, registered.
REQ-017 sram_dq  inout  16  SRAM data; driven only during writes, otherwise Z.
REQ-018 sram_addr  out  18; sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each, active-low SRAM strobes.
REQ-019 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-020 FSM states SHALL be IDLE, RD, WR, WR_HOLD, ACK.
REQ-021 IDLE: with no request pending, all SRAM strobes SHALL be high and sram_dq SHALL be Z.
REQ-022 Arbitration in IDLE SHALL grant video over host, except that host SHALL win when starve_cnt == STARVE.
REQ-023 starve_cnt SHALL increment on each video grant while host_req=1, clear on a host grant or whenever host_req=0, and saturate at STARVE.
REQ-024 On a grant, sram_addr, the byte enables, the write data and the owner SHALL be registered, and the FSM SHALL enter RD or WR on the next edge.
REQ-025 Video grants SHALL drive ub_n=lb_n=0; host grants SHALL drive ub_n=~host_be[1] and lb_n=~host_be[0].
REQ-026 RD: ce_n=0 and oe_n=0 for exactly RD_CYC cycles; sram_dq SHALL be sampled at the last RD cycle, then the FSM SHALL enter ACK.
REQ-027 WR: ce_n=0, we_n=0 and dq driven for WR_CYC cycles, then WR_HOLD.
REQ-028 WR_HOLD (1 cycle): we_n=1, ce_n=0, with dq and address still driven so the SRAM sees data/address hold; the FSM SHALL then enter ACK.
REQ-029 ACK (1 cycle): the owner's ack SHALL be 1, all strobes high, dq Z; the FSM SHALL then go to IDLE.
REQ-030 Requests SHALL NOT be sampled in the ACK cycle.
REQ-031 Read latency from the req-sampled edge to ack SHALL be RD_CYC+1 cycles; write latency SHALL be WR_CYC+2 cycles.
REQ-032 Minimum request spacing SHALL be RD_CYC+2 cycles for reads and WR_CYC+3 cycles for writes.
REQ-033 Simultaneous vid_req and host_req with starve_cnt < STARVE SHALL grant video; the host request SHALL remain pending.
REQ-034 host_be=00 on a write SHALL still run the full write cycle with ub_n=lb_n=1 and SHALL be acked.
REQ-035 Dropping req before ack is illegal; the access SHALL still complete and ack.
REQ-036 rdata registers SHALL hold their value until the next read by the same owner.

Reset
REQ-037 While rst=1: FSM=IDLE, starve_cnt=0, ce_n=oe_n=we_n=ub_n=lb_n=1, sram_addr=0, dq Z, acks=0, rdata=0, busy=0.
REQ-038 rst during RD, WR or WR_HOLD SHALL abort at the next edge: strobes high, no ack issued, request discarded.

Structure
REQ-039 State encoding and the default RD_CYC/WR_CYC/STARVE values SHALL live in the shared package sram_pkg.
REQ-040 The single sub-module sram_phy SHALL own the registered strobes, the dq tristate and the read-sample register; the FSM and arbitration SHALL stay in sram_arbiter.

Verification
REQ-041 Host write 0x2A5C5 data 0xBEEF be=11, then host read 0x2A5C5 -> host_rdata=0xBEEF; write ack at +4, read ack at +3 cycles.
REQ-042 Host write be=01 data 0x1234 over stored 0xBEEF, then read -> 0xBE34; ub_n=1 throughout the write.
REQ-043 vid_req held continuously with host_req raised -> host granted after exactly 8 video acks; starve_cnt returns to 0.
REQ-044 vid_req and host_req rise in the same cycle -> vid_ack first, host_ack on the next arbitration.
REQ-045 rst pulsed in the 2nd WR cycle -> strobes high and dq Z at the next edge, no host_ack, next request served normally.
REQ-046 Model check every cycle: oe_n and we_n never both 0; dq driven only in WR/WR_HOLD.
